alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 54 +++++
 rtl/alu_arbiter.sv | 104 ++++++++++
 tb/tb_alu_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU, response and counter signals for alu_arbiter.
// Latency: none (wires only).
// Backpressure: carried by req*_ready / rsp_ready inside the bundle.
interface alu_arbiter_if;
  // requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_op_a;
  logic [31:0] req0_op_b;
  logic [3:0]  req0_ctrl;
  // requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_op_a;
  logic [31:0] req1_op_b;
  logic [3:0]  req1_ctrl;
  // shared combinational ALU
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  // response register
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  // per-requester grant counters
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;

  // arbiter side
  modport slave (
    input  req0_valid, req0_op_a, req0_op_b, req0_ctrl,
    input  req1_valid, req1_op_a, req1_op_b, req1_ctrl,
    input  alu_result, alu_flags, rsp_ready,
    output req0_ready, req1_ready,
    output alu_operand_a, alu_operand_b, alu_control,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    output gnt_cnt0, gnt_cnt1
  );

  // requesters / ALU / consumer side
  modport master (
    output req0_valid, req0_op_a, req0_op_b, req0_ctrl,
    output req1_valid, req1_op_a, req1_op_b, req1_ctrl,
    output alu_result, alu_flags, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_operand_a, alu_operand_b, alu_control,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Latency: result registered 1 cycle after the accepting edge; 1 op/cycle sustained.
// Backpressure: held response with rsp_ready low blocks both requesters (ready low).
module alu_arbiter (
  input logic        clk,
  input logic        rst_n,
  alu_arbiter_if.slave bus
);

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        last_gnt_q, last_gnt_d;
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

  logic can_accept;
  logic gnt0, gnt1;
  logic xfer0, xfer1;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  // Ready is also suppressed while reset is held so nothing is accepted then.
  always_comb begin
    can_accept = !rsp_valid_q || bus.rsp_ready;
    gnt0       = bus.req0_valid && (!bus.req1_valid || last_gnt_q);
    gnt1       = bus.req1_valid && (!bus.req0_valid || !last_gnt_q);
    xfer0      = gnt0 && can_accept && rst_n;
    xfer1      = gnt1 && can_accept && rst_n;
  end

  assign bus.req0_ready = xfer0;
  assign bus.req1_ready = xfer1;

  // Steer the accepted requester onto the shared ALU; idle drives zeros.
  always_comb begin
    bus.alu_operand_a = 32'd0;
    bus.alu_operand_b = 32'd0;
    bus.alu_control   = 4'b0000;
    if (xfer0) begin
      bus.alu_operand_a = bus.req0_op_a;
      bus.alu_operand_b = bus.req0_op_b;
      bus.alu_control   = bus.req0_ctrl;
    end else if (xfer1) begin
      bus.alu_operand_a = bus.req1_op_a;
      bus.alu_operand_b = bus.req1_op_b;
      bus.alu_control   = bus.req1_ctrl;
    end
  end

  // Next state: reload the response on a transfer, drop it when drained,
  // otherwise hold; counters saturate at all-ones.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    last_gnt_d   = last_gnt_q;
    gnt_cnt0_d   = gnt_cnt0_q;
    gnt_cnt1_d   = gnt_cnt1_q;

    if (xfer0 || xfer1) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = xfer1;
      rsp_result_d = bus.alu_result;
      rsp_flags_d  = bus.alu_flags;
      last_gnt_d   = xfer1;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end

    if (xfer0 && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (xfer1 && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  // State registers; last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 4'd0;
      last_gnt_q   <= 1'b1;
      gnt_cnt0_q   <= 16'd0;
      gnt_cnt1_q   <= 16'd0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      last_gnt_q   <= last_gnt_d;
      gnt_cnt0_q   <= gnt_cnt0_d;
      gnt_cnt1_q   <= gnt_cnt1_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.gnt_cnt0   = gnt_cnt0_q;
  assign bus.gnt_cnt1   = gnt_cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: checks ready in-cycle and response one edge after acceptance.
// Backpressure: randomizes rsp_ready to exercise stalls and drains.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0010;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core ALU: {carry, overflow, negative, zero} in the low nibble of the return.
  function automatic logic [35:0] alu_ref(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    logic        v;
    logic [32:0] wide;
    c = 1'b0;
    v = 1'b0;
    case (ctrl)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = (a ^ b) + {28'd0, ctrl};
    endcase
    return {r, c, v, r[31], (r == 32'd0)};
  endfunction

  always_comb begin
    logic [35:0] o;
    o = alu_ref(bus.alu_control, bus.alu_operand_a, bus.alu_operand_b);
    bus.alu_result = o[35:4];
    bus.alu_flags  = o[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_ctrl = ctrl; bus.req0_op_a = a; bus.req0_op_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_ctrl = ctrl; bus.req1_op_a = a; bus.req1_op_b = b;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state
  bit          m_valid;
  bit          m_id;
  logic [31:0] m_result;
  logic [3:0]  m_flags;
  int          m_last;
  int          m_cnt[2];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;
    logic        v0, v1, rr;
    logic [35:0] o;
    int          w;
    bit          acc;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;

    // ---- single request ADD 5,7 ----
    do_reset();
    chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_result", bus.rsp_result, 32'd0);
    chk("rst_flags", {28'd0, bus.rsp_flags}, 32'd0);
    chk("rst_cnt0", {16'd0, bus.gnt_cnt0}, 32'd0);
    chk("idle_ctrl", {28'd0, bus.alu_control}, 32'd0);
    chk("idle_opa", bus.alu_operand_a, 32'd0);
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    chk("single_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    chk("single_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("single_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("single_result", bus.rsp_result, 32'd12);
    chk("single_flags", {28'd0, bus.rsp_flags}, 32'd0);
    chk("single_cnt0", {16'd0, bus.gnt_cnt0}, 32'd1);
    @(negedge clk);

    // ---- tie after reset: alternating grants ----
    do_reset();
    set_req(0, 1'b1, OP_SUB, 32'd3, 32'd3);
    set_req(1, 1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_rdy0", {31'd0, bus.req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_rdy1", {31'd0, bus.req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk("tie_id", {31'd0, bus.rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("tie_result", bus.rsp_result, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("tie_flags", {28'd0, bus.rsp_flags}, (i % 2 == 0) ? 32'b0001 : 32'b0000);
      @(negedge clk);
    end

    // ---- backpressure: response from req1 held for 3 cycles ----
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy0", {31'd0, bus.req0_ready}, 32'd0);
      chk("bp_rdy1", {31'd0, bus.req1_ready}, 32'd0);
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_id", {31'd0, bus.rsp_id}, 32'd1);
      chk("bp_result", bus.rsp_result, 32'd1);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("drain_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    chk("drain_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("drain_flags", {28'd0, bus.rsp_flags}, 32'b0001);
    chk("drain_cnt0", {16'd0, bus.gnt_cnt0}, 32'd3);
    chk("drain_cnt1", {16'd0, bus.gnt_cnt1}, 32'd2);
    @(negedge clk);

    // ---- overflow flags from req1 ----
    set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    @(posedge clk); #1;
    chk("ovf_id", {31'd0, bus.rsp_id}, 32'd1);
    chk("ovf_result", bus.rsp_result, 32'h8000_0000);
    chk("ovf_flags", {28'd0, bus.rsp_flags}, 32'b0110);
    @(negedge clk);

    // ---- reset mid-flight with a held response ----
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    set_req(1, 1'b1, OP_ADD, 32'd3, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_result", bus.rsp_result, 32'd0);
    chk("mid_rst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
    chk("mid_rst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    chk("post_rst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("post_rst_result", bus.rsp_result, 32'd3);
    @(negedge clk);

    // ---- randomized traffic vs reference model ----
    do_reset();
    m_valid = 0; m_id = 0; m_result = 0; m_flags = 0; m_last = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      a0 = $urandom; b0 = $urandom; c0 = 4'($urandom_range(0, 15));
      a1 = $urandom; b1 = $urandom; c1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) c0 = OP_ADD;
      if ($urandom_range(0, 3) == 0) c1 = OP_SUB;
      set_req(0, v0, c0, a0, b0);
      set_req(1, v1, c1, a1, b1);
      bus.rsp_ready = rr;

      acc = !m_valid || rr;
      w = -1;
      if (acc) begin
        if (v0 && v1) w = 1 - m_last;
        else if (v0)  w = 0;
        else if (v1)  w = 1;
      end
      #1;
      chk("rnd_rdy0", {31'd0, bus.req0_ready}, (w == 0) ? 32'd1 : 32'd0);
      chk("rnd_rdy1", {31'd0, bus.req1_ready}, (w == 1) ? 32'd1 : 32'd0);
      chk("rnd_ctrl", {28'd0, bus.alu_control}, (w == 0) ? {28'd0, c0} : (w == 1) ? {28'd0, c1} : 32'd0);
      chk("rnd_opb", bus.alu_operand_b, (w == 0) ? b0 : (w == 1) ? b1 : 32'd0);

      if (w >= 0) begin
        o = (w == 0) ? alu_ref(c0, a0, b0) : alu_ref(c1, a1, b1);
        m_valid  = 1;
        m_id     = (w == 1);
        m_result = o[35:4];
        m_flags  = o[3:0];
        m_last   = w;
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end else if (rr) begin
        m_valid = 0;
      end

      @(posedge clk); #1;
      chk("rnd_valid", {31'd0, bus.rsp_valid}, {31'd0, m_valid});
      chk("rnd_id", {31'd0, bus.rsp_id}, {31'd0, m_id});
      chk("rnd_result", bus.rsp_result, m_result);
      chk("rnd_flags", {28'd0, bus.rsp_flags}, {28'd0, m_flags});
      chk("rnd_cnt0", {16'd0, bus.gnt_cnt0}, 32'(m_cnt[0]));
      chk("rnd_cnt1", {16'd0, bus.gnt_cnt1}, 32'(m_cnt[1]));
      @(negedge clk);
    end

    // ---- counter saturation on requester 0 ----
    do_reset();
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    bus.rsp_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_cnt0_fffe", {16'd0, bus.gnt_cnt0}, 32'h0000_FFFE);
    @(posedge clk); #1;
    chk("sat_cnt0_ffff", {16'd0, bus.gnt_cnt0}, 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_cnt0_hold", {16'd0, bus.gnt_cnt0}, 32'h0000_FFFF);
    chk("sat_cnt1", {16'd0, bus.gnt_cnt1}, 32'd0);
    chk("sat_valid", {31'd0, bus.rsp_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
